// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit writing the HI/LO registers.
// Optional zero-operand fast path is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_out_q;

  // Signed ops (op[0]==0) run on magnitudes; signs are reapplied in FIX.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic             early_out;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  assign abs_a     = a_neg ? -A : A;
  assign abs_b     = b_neg ? -B : B;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = op[1] ? ((A == '0) && (B != '0)) : ((A == '0) || (B == '0));
`else
  assign early_out = 1'b0;
`endif

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // NOTE: every branch of an always_comb must assign every output it drives, or a latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_trial >= {1'b0, b_q};
    div_diff  = div_trial[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      acc_step = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = neg_q_q ? -acc_q : acc_q;
    quo  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!flush) begin
              is_div_q <= op[1];
              neg_q_q  <= a_neg ^ b_neg;
              neg_r_q  <= a_neg;
              dz_q     <= op[1] && (B == '0);
              b_q      <= op[1] ? abs_b : abs_a;
              acc_q    <= early_out ? '0 : {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
              cnt_q    <= CNT_W'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= early_out ? FIX : RUN;
            end
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q   <= 1'b1;
            dz_out_q <= dz_q;
            if (is_div_q) begin
              // Divide by zero leaves an all-ones quotient; the remainder already equals A.
              lo_q <= dz_q ? '1 : quo;
              hi_q <= rem;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a per-cycle
// compare process, directed cases with literal results, and randomized operations.
module tb_muldiv_unit;

  localparam int WIDTH    = 32;
  // Edges from the edge that samples start to the edge that raises done (done seen in cycle N+34).
  localparam int LAT_FULL = WIDTH + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .A          (a_in),
    .B          (b_in),
    .flush      (flush),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a; rl = '1; rdz = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          rh = r[31:0]; rl = q[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  function automatic bit early(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return EARLY_EN && (o[1] ? (a == 0 && b != 0) : (a == 0 || b == 0));
  endfunction

  // Reference model: pending result plus a count of edges left until it lands.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int          remaining = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; remaining = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (remaining > 0) begin
        if (flush) begin
          remaining = 0;
          m_busy    = 1'b0;
        end else begin
          remaining--;
          if (remaining == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1; m_busy = 1'b0;
          end
        end
      end else if (start) begin
        if (!flush) begin
          ref_result(op, a_in, b_in, p_hi, p_lo, p_dz);
          remaining = early(op, a_in, b_in) ? 1 : LAT_FULL;
          m_busy    = 1'b1;
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  initial begin
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cyc_busy", busy, m_busy);
        check("cyc_done", done, m_done);
        check("cyc_dz", div_by_zero, m_dz);
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_done(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = int'(busy);
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      busy_cnt += int'(busy);
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk); hi_we = 1'b1; wdata = h;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = l;
    @(negedge clk); lo_we = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n, bc;
    logic [31:0] rh, rl, ra, rb;
    logic        rdz;
    logic [1:0]  ro;

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Literal pins on the reference model itself.
    ref_result(2'd0, 32'd7, 32'hFFFF_FFFD, rh, rl, rdz);
    check("model_mult_hi", rh, 32'hFFFF_FFFF);
    check("model_mult_lo", rl, 32'hFFFF_FFEB);
    ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rdz);
    check("model_ovf_lo", rl, 32'h8000_0000);
    check("model_ovf_hi", rh, 32'h0);

    // MULT 7 * -3
    launch(2'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(n, bc);
    check("t1_latency", n, LAT_FULL);
    check("t1_busy_cycles", bc, 33);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100/7, DIV -7/2
    launch(2'd3, 32'd100, 32'd7);
    wait_done(n, bc);
    check("t2a_lo", lo, 32'd14);
    check("t2a_hi", hi, 32'd2);
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bc);
    check("t2b_lo", lo, 32'hFFFF_FFFD);
    check("t2b_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero, then signed overflow
    launch(2'd2, 32'h1234_5678, 32'd0);
    wait_done(n, bc);
    check("t3a_latency", n, LAT_FULL);
    check("t3a_dz", div_by_zero, 1'b1);
    check("t3a_lo", lo, 32'hFFFF_FFFF);
    check("t3a_hi", hi, 32'h1234_5678);
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    check("t3b_dz", div_by_zero, 1'b0);
    check("t3b_lo", lo, 32'h8000_0000);
    check("t3b_hi", hi, 32'h0);

    // MULTU with start/hi_we/lo_we attempted while busy
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (8) @(negedge clk);
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; op = 2'd2; a_in = 32'd5; b_in = 32'd1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(n, bc);
    check("t4_hi", hi, 32'hFFFF_FFFE);
    check("t4_lo", lo, 32'h0000_0001);
    @(negedge clk); lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk); lo_we = 1'b0;
    check("t4_mtlo", lo, 32'hA5A5_A5A5);
    check("t4_hi_kept", hi, 32'hFFFF_FFFE);

    // start with flush in IDLE is dropped
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'd1; a_in = 32'd3; b_in = 32'd3;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", busy, 1'b0);

    // start together with hi_we in IDLE: start wins
    @(negedge clk); start = 1'b1; hi_we = 1'b1; wdata = 32'h777; op = 2'd3; a_in = 32'd9; b_in = 32'd4;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    check("start_wins_hi", hi, 32'hFFFF_FFFE);
    wait_done(n, bc);
    check("start_wins_lo", lo, 32'd2);
    check("start_wins_rem", hi, 32'd1);

    // Flush mid-operation
    write_hilo(32'h11, 32'h22);
    launch(2'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_flush_busy", busy, 1'b0);
    check("t5_flush_done", done, 1'b0);
    repeat (40) @(negedge clk);
    check("t5_flush_hi", hi, 32'h11);
    check("t5_flush_lo", lo, 32'h22);

    // Asynchronous reset mid-operation
    launch(2'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_dz", div_by_zero, 1'b0);
    check("t5_rst_hi", hi, 32'h0);
    check("t5_rst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero operand: fast path only when the feature is built in
    write_hilo(32'h33, 32'h44);
    launch(2'd0, 32'd0, 32'd5);
    wait_done(n, bc);
    check("t6_latency", n, EARLY_EN ? 1 : LAT_FULL);
    check("t6_hi", hi, 32'h0);
    check("t6_lo", lo, 32'h0);

    // Randomized operations with occasional mthi/mtlo and flushes
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      if ($urandom_range(0, 4) == 0) write_hilo($urandom, $urandom);
      launch(ro, ra, rb);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end else begin
        wait_done(n, bc);
        check("rand_latency", n, early(ro, ra, rb) ? 1 : LAT_FULL);
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, next to the main ALU and fed from the same ID/EX operand bus (A, B).
- Takes over the slow 32x32 multiply and divide work from the combinational ALU path.
- Writes results into architectural HI/LO registers, which the writeback mux reads for mfhi/mflo.
- Holds the pipeline via busy until the result is ready.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new operation; sampled only in IDLE
op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
A  in  WIDTH  multiplicand / dividend (rs)
B  in  WIDTH  multiplier / divisor (rt)
flush  in  1  pipeline flush; aborts an in-flight operation
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
busy  out  1  operation in progress; stalls the pipeline
done  out  1  one-cycle pulse; HI/LO are updated
div_by_zero  out  1  one-cycle pulse with done when DIV/DIVU had B==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 → latch op.
  - For signed ops, latch |A| and |B|, and record result signs: product sign = A[msb]^B[msb]; quotient sign = A^B sign; remainder sign = A sign.
  - Load counter=WIDTH, go to RUN. busy=1 from the next cycle.
- RUN, multiply: radix-2 shift-add. One bit per cycle into a 2*WIDTH accumulator.
- RUN, divide: restoring. One quotient bit per cycle.
- RUN, counter: decrements each cycle; at 1 → FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - Go to IDLE.
- done and div_by_zero are registered; they pulse in the first IDLE cycle after FIX.
- Latency: start sampled at edge N → done high in cycle N+WIDTH+2 (34 for WIDTH=32). busy is high during RUN and FIX, and low when done is high.
- Divide by zero (B==0): no trap. lo=all ones, hi=A (unsigned value for DIVU, signed value for DIV). div_by_zero pulses with done. Full latency still applies.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the magnitude algorithm). No flag.
- Busy interactions:
  - start while busy: ignored.
  - hi_we/lo_we while busy: ignored.
  - start together with hi_we/lo_we in IDLE: start wins and the writes are dropped.
- mthi/mtlo in IDLE: hi/lo update on the next edge. hi_we and lo_we may both be set in the same cycle.
- flush in RUN/FIX: return to IDLE next edge; hi/lo unchanged; no done pulse. flush in IDLE has no effect, and start in the same cycle is dropped.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Operands are captured at start; A/B/op may change afterwards with no effect.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: a zero-operand fast path.
  - Multiply with A==0 or B==0: RUN is skipped and hi=lo=0; done at N+2.
  - DIV/DIVU with A==0 and B!=0: hi=lo=0; done at N+2.
  - Divide by zero is unaffected and keeps full latency.
- Undefined: every operation takes exactly WIDTH+2 cycles to done.

Test Plan:
1. MULT A=7, B=0xFFFFFFFD (-3) → done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
2. DIVU A=100, B=7 → lo=14, hi=2. DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV A=0x12345678, B=0 → div_by_zero pulse with done; lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. Start MULTU 0xFFFFFFFF*0xFFFFFFFF. Assert start, hi_we, and lo_we at cycle 10 → all ignored. Result hi=0xFFFFFFFE, lo=0x00000001. Then lo_we=1, wdata=0xA5A5A5A5 in IDLE → lo=0xA5A5A5A5.
5. Preload hi=0x11, lo=0x22. Start DIV, flush at cycle 5 → IDLE next cycle; no done; hi/lo still 0x11/0x22. Repeat with rst_n=0 at cycle 5 → all outputs 0 asynchronously.
6. With MULDIV_EARLY_OUT_EN: MULT A=0, B=5 → done at start+2, hi=lo=0. Without the macro the same stimulus gives done at start+34.
